// File: rtl/a_pkg.sv
// Shared definitions for the async-boundary blocks: capture FSM state type and
// a pointer-width helper that stays legal for tiny depths.
package a_pkg;

    // Capture FSM: IDLE waits for a pending token, HOLD lets a_q settle vs r_s.
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } cap_state_e;

    // Pointer width for a FIFO of the given depth; never returns zero.
    function automatic int unsigned ptr_width(input int unsigned depth);
        if (depth <= 32'd1) begin
            return 32'd1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/a_sync_ff.sv
// Multi-flop synchroniser chain. Resets every stage to INIT so that the
// synchronised value matches the idle level of the signal it samples.
module a_sync_ff #(
    parameter int unsigned W      = 32'd1,
    parameter int unsigned STAGES = 32'd2,
    parameter logic [W-1:0] INIT  = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] chain_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= {STAGES{INIT}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/a_sync_sink.sv
// Terminates a 2-phase bundled-data channel: synchronises r_i, captures d_i
// into a small FIFO, returns the ack transition on the capture edge, and
// presents the FIFO head as a valid/ready stream.
(* keep_hierarchy *)
module a_sync_sink
    import a_pkg::*;
#(
    parameter logic        Rpol        = 1'b0,
    parameter int unsigned N           = 32'd1,
    parameter int unsigned DEPTH       = 32'd4,
    parameter int unsigned SYNC_STAGES = 32'd2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    r_i,
    output logic                    a_i,
    input  logic [N-1:0]            d_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [N-1:0]            d_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int unsigned AW = ptr_width(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 32'd1;

    logic           r_s;
    logic           a_q, a_d;
    cap_state_e     state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [N-1:0]   mem_q [DEPTH];
    logic           pending_s, full_s, valid_s, push_s, pop_s;

    a_sync_ff #(
        .W      (32'd1),
        .STAGES (SYNC_STAGES),
        .INIT   (Rpol)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (r_i),
        .q_o (r_s)
    );

    // A token is outstanding whenever the synchronised request differs from our ack.
    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        pending_s = (r_s != a_q);
        full_s    = (count_q == CW'(DEPTH));
        valid_s   = (count_q != CW'(0));
        pop_s     = valid_s & ready_i;
    end

    // Capture FSM: write and ack on the same edge, then one HOLD cycle so the
    // toggled ack is compared against a settled r_s before the next capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        push_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (pending_s && !full_s) begin
                    push_s  = 1'b1;
                    a_d     = ~a_q;
                    state_d = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO pointer and occupancy next-state; pointers wrap by power-of-2 overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state registers; reset discards everything and parks ack at Rpol.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= Rpol;
            wr_ptr_q <= AW'(0);
            rd_ptr_q <= AW'(0);
            count_q  <= CW'(0);
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= d_i;
        end
    end

    assign a_i     = a_q;
    assign valid_o = valid_s;
    assign d_o     = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: tb/tb_a_sync_sink.sv
// Directed bench for a_sync_sink: two instances (Rpol=0 and Rpol=1), an
// upstream 2-phase driver, and a scoreboard of expected output data.
module tb_a_sync_sink;

    logic       clk = 1'b0;
    logic       rst;
    logic       r0, a0, v0, rdy0;
    logic [7:0] d0i, d0o;
    logic [2:0] c0;
    logic       r1, a1, v1, rdy1;
    logic [7:0] d1i, d1o;
    logic [2:0] c1;

    int         checks = 0;
    int         errors = 0;
    int         acks   = 0;
    int         pops   = 0;
    logic [7:0] sb[$];
    bit         rand_en = 1'b0;
    logic [7:0] lfsr = 8'h5B;

    always #5 clk = ~clk;

    a_sync_sink #(.Rpol(1'b0), .N(32'd8), .DEPTH(32'd4), .SYNC_STAGES(32'd2)) dut0 (
        .clk(clk), .rst(rst), .r_i(r0), .a_i(a0), .d_i(d0i),
        .valid_o(v0), .ready_i(rdy0), .d_o(d0o), .count_o(c0)
    );

    a_sync_sink #(.Rpol(1'b1), .N(32'd8), .DEPTH(32'd4), .SYNC_STAGES(32'd2)) dut1 (
        .clk(clk), .rst(rst), .r_i(r1), .a_i(a1), .d_i(d1i),
        .valid_o(v1), .ready_i(rdy1), .d_o(d1o), .count_o(c1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock for dut0: score a pop that happens on this edge, count ack toggles.
    task automatic step0();
        logic       a_prev;
        logic [7:0] exp;
        if (v0 === 1'b1 && rdy0 === 1'b1) begin
            pops++;
            if (sb.size() == 0) begin
                chk("pop_with_empty_scoreboard", 32'd1, 32'd0);
            end else begin
                exp = sb.pop_front();
                chk("d_o", {24'd0, d0o}, {24'd0, exp});
            end
        end
        a_prev = a0;
        @(posedge clk);
        #1;
        if (a0 !== a_prev) acks++;
        if (rand_en) begin
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rdy0 = lfsr[0];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send0(input logic [7:0] v);
        d0i = v;
        r0  = ~r0;
        sb.push_back(v);
    endtask

    task automatic wait_ack0(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step0();
            if (a0 === r0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int acks_base, pops_base;

        // Reset state
        rst = 1'b1; r0 = 1'b0; r1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
        d0i = 8'h00; d1i = 8'h00;
        tick(); tick();
        chk("rst_a0", a0, 1'b0);
        chk("rst_valid0", v0, 1'b0);
        chk("rst_count0", c0, 3'd0);
        chk("rst_a1", a1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_hold_a0", a0, 1'b0);
            chk("rst_hold_valid0", v0, 1'b0);
            chk("rst_hold_count0", c0, 3'd0);
        end
        rst = 1'b0;
        tick(); tick();

        // Single token: ack on edge 3, valid visible from edge 3 (seen at edge 4)
        send0(8'hA5);
        step0();
        chk("tok_e1_a", a0, 1'b0);
        step0();
        chk("tok_e2_a", a0, 1'b0);
        chk("tok_e2_valid", v0, 1'b0);
        step0();
        chk("tok_e3_a", a0, 1'b1);
        chk("tok_e3_valid", v0, 1'b1);
        chk("tok_e3_count", c0, 3'd1);
        rdy0 = 1'b1;
        step0();
        chk("tok_pop_count", c0, 3'd0);
        chk("tok_pop_valid", v0, 1'b0);
        rdy0 = 1'b0;
        tick();

        // Fill: 4 tokens acked, 5th held back
        acks_base = acks;
        for (int k = 1; k <= 4; k++) begin
            send0(k[7:0]);
            wait_ack0(10, ok);
            chk("fill_ack", {31'd0, ok}, 32'd1);
        end
        chk("fill_count", c0, 3'd4);
        send0(8'd5);
        for (int i = 0; i < 6; i++) step0();
        chk("fill_5th_no_ack", a0 === r0, 1'b0);
        chk("fill_count_still4", c0, 3'd4);
        chk("fill_acks", acks - acks_base, 32'd4);

        // Drain: 5th ack within 2 clk of the first pop
        pops_base = pops;
        rdy0 = 1'b1;
        step0();
        ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step0();
            if (a0 === r0) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_5th_ack", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 40 && (sb.size() != 0 || v0 === 1'b1); i++) step0();
        chk("drain_pops", pops - pops_base, 32'd5);
        chk("drain_sb_empty", sb.size(), 32'd0);
        chk("drain_count", c0, 3'd0);

        // Wrap: 10 tokens with pseudo-random ready
        acks_base = acks;
        pops_base = pops;
        rand_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send0(k[7:0]);
            wait_ack0(60, ok);
            chk("wrap_ack", {31'd0, ok}, 32'd1);
        end
        rand_en = 1'b0;
        rdy0 = 1'b1;
        for (int i = 0; i < 40 && (sb.size() != 0 || v0 === 1'b1); i++) step0();
        chk("wrap_acks", acks - acks_base, 32'd10);
        chk("wrap_pops", pops - pops_base, 32'd10);
        chk("wrap_sb_empty", sb.size(), 32'd0);
        rdy0 = 1'b0;

        // Mid-operation reset between clock edges
        send0(8'h11);
        wait_ack0(10, ok);
        chk("mid_ack1", {31'd0, ok}, 32'd1);
        send0(8'h22);
        wait_ack0(10, ok);
        chk("mid_ack2", {31'd0, ok}, 32'd1);
        send0(8'h33);
        step0();
        chk("mid_count2", c0, 3'd2);
        #2;
        rst = 1'b1;
        r0  = 1'b0;
        #1;
        chk("mid_valid", v0, 1'b0);
        chk("mid_count", c0, 3'd0);
        chk("mid_a", a0, 1'b0);
        sb.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step0();
            chk("post_rst_valid", v0, 1'b0);
            chk("post_rst_a", a0, 1'b0);
        end

        // Rpol=1 single token on dut1
        d1i = 8'h3C;
        r1  = 1'b0;
        tick();
        chk("p1_e1_a", a1, 1'b1);
        tick();
        chk("p1_e2_a", a1, 1'b1);
        chk("p1_e2_valid", v1, 1'b0);
        tick();
        chk("p1_e3_a", a1, 1'b0);
        chk("p1_e3_valid", v1, 1'b1);
        chk("p1_e3_d", {24'd0, d1o}, 32'h3C);
        chk("p1_e3_count", c1, 3'd1);
        rdy1 = 1'b1;
        tick();
        chk("p1_pop_count", c1, 3'd0);
        chk("p1_pop_valid", v1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
